// File: rtl/rotate_request_sequencer_pkg.sv
// rotate_request_sequencer_pkg: shared widths, request type and direction-to-amount helper
package rotate_pkg;
    localparam int DATA_W = 16;
    localparam int AMT_W = 4;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  s;
    } rot_req_t;
    function automatic logic [AMT_W-1:0] to_right_amt(input logic [AMT_W-1:0] amt, input logic dir);
        return dir ? ~amt + AMT_W'(1) : amt;
    endfunction
endpackage

// File: rtl/rotate_request_sequencer_if.sv
// rotate_request_sequencer_if: request, rotator and result signals of the sequencer
interface rotate_request_sequencer_if #(parameter int DEPTH = 4);
    logic                         in_valid;
    logic                         in_ready;
    logic [15:0]                  in_data;
    logic [3:0]                   in_amt;
    logic                         in_dir;
    logic [15:0]                  rot_aa;
    logic [3:0]                   rot_s;
    logic [15:0]                  rot_sho;
    logic                         out_valid;
    logic                         out_ready;
    logic [15:0]                  out_data;
    logic [$clog2(DEPTH+1)-1:0]   count;
    modport slave (
        input  in_valid, in_data, in_amt, in_dir, rot_sho, out_ready,
        output in_ready, rot_aa, rot_s, out_valid, out_data, count
    );
    modport master (
        output in_valid, in_data, in_amt, in_dir, rot_sho, out_ready,
        input  in_ready, rot_aa, rot_s, out_valid, out_data, count
    );
endinterface

// File: rtl/rotate_request_sequencer_fifo.sv
// rotate_req_fifo: power-of-two request FIFO with combinational head and occupancy count
module rotate_req_fifo import rotate_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  rot_req_t                   din_i,
    output rot_req_t                   head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    rot_req_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    // Storage is written only on accepted pushes; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop) rd_q <= rd_q + PW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/rotate_request_sequencer.sv
// rotate_request_sequencer: buffers rotate requests, drives the rotator from the FIFO head and registers results
module rotate_request_sequencer import rotate_pkg::*; #(
    parameter int DEPTH = 4
) (
    input logic                         clk,
    input logic                         rst,
    rotate_request_sequencer_if.slave   bus
);
    rot_req_t           req, head;
    logic               full, empty, push, pop;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    assign req  = '{data: bus.in_data, s: to_right_amt(bus.in_amt, bus.in_dir)};
    assign push = bus.in_valid && !full;
    assign pop  = !empty && (!out_valid_q || bus.out_ready);
    rotate_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (req),
        .head_o  (head),
        .count_o (bus.count),
        .full_o  (full),
        .empty_o (empty)
    );
    assign bus.in_ready  = !full;
    assign bus.rot_aa    = empty ? '0 : head.data;
    assign bus.rot_s     = empty ? '0 : head.s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    // Result register: capture on pop, drop valid when consumed with nothing behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.rot_sho;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rotate_request_sequencer.sv
// tb_rotate_request_sequencer: directed and scoreboarded checks of the rotate request sequencer
module tb_rotate_request_sequencer;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    rotate_request_sequencer_if #(.DEPTH(4)) bus ();
    rotate_request_sequencer #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [31:0] dbl;
    assign dbl = {bus.rot_aa, bus.rot_aa} >> bus.rot_s;
    assign bus.rot_sho = dbl[15:0];

    function automatic logic [15:0] rotr(input logic [15:0] d, input int s);
        return (s == 0) ? d : ((d >> s) | (d << (16 - s)));
    endfunction
    function automatic logic [15:0] rotl(input logic [15:0] d, input int s);
        return (s == 0) ? d : ((d << s) | (d >> (16 - s)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a, input logic dir);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_dir   = dir;
    endtask

    task automatic send_one(input string tag, input logic [15:0] d, input logic [3:0] a, input logic dir,
                            input logic [3:0] exp_s, input logic [15:0] exp_out);
        drive(1'b1, d, a, dir);
        bus.out_ready = 1'b1;
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check({tag, "_count"}, 32'(bus.count), 32'd1);
        check({tag, "_rot_s"}, 32'(bus.rot_s), 32'(exp_s));
        check({tag, "_rot_aa"}, 32'(bus.rot_aa), 32'(d));
        step();
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp_out));
        check({tag, "_drained"}, 32'(bus.count), 32'd0);
    endtask

    logic [15:0] exp_q[$];
    logic [15:0] prev_data;
    logic        do_push, do_take, hold;
    logic [15:0] head_exp;
    int          full_swap = 0;

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_aa", 32'(bus.rot_aa), 32'd0);
        check("rst_s", 32'(bus.rot_s), 32'd0);

        send_one("right1", 16'h0001, 4'd1, 1'b0, 4'd1, 16'h8000);
        send_one("left1", 16'h0001, 4'd1, 1'b1, 4'd15, 16'h0002);
        send_one("left0", 16'hABCD, 4'd0, 1'b1, 4'd0, 16'hABCD);

        bus.out_ready = 1'b1;
        step();
        check("idle_drain", 32'(bus.out_valid), 32'd0);
        check("idle_hold_data", 32'(bus.out_data), 32'h0000ABCD);
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1234, 4'd4, 1'b0);
        step();
        drive(1'b1, 16'h00FF, 4'd8, 1'b0);
        check("bp_ready1", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_first", 32'(bus.out_data), 32'h00004123);
        drive(1'b1, 16'hF00F, 4'd4, 1'b1);
        step();
        drive(1'b1, 16'h8000, 4'd1, 1'b1);
        step();
        drive(1'b1, 16'h0003, 4'd2, 1'b0);
        check("bp_ready4", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b1, 16'h5A5A, 4'd1, 1'b0);
        check("bp_full_count", 32'(bus.count), 32'd4);
        check("bp_full_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("bp_stall_count", 32'(bus.count), 32'd4);
        check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
        check("bp_stall_data", 32'(bus.out_data), 32'h00004123);
        bus.out_ready = 1'b1;
        step();
        check("bp_r1", 32'(bus.out_data), 32'h0000FF00);
        check("bp_no_passthru", 32'(bus.count), 32'd3);
        check("bp_ready_again", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("bp_r2", 32'(bus.out_data), 32'h000000FF);
        check("bp_swap_count", 32'(bus.count), 32'd3);
        step();
        check("bp_r3", 32'(bus.out_data), 32'h00000001);
        step();
        check("bp_r4", 32'(bus.out_data), 32'h0000C000);
        step();
        check("bp_r5", 32'(bus.out_data), 32'h00002D2D);
        check("bp_r5_valid", 32'(bus.out_valid), 32'd1);
        step();
        check("bp_empty_valid", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(1'b1, 16'h8001, 4'(i), 1'b0);
            else drive(1'b0, 16'h0, 4'h0, 1'b0);
            step();
            check("stream_count_le1", 32'(bus.count <= 1), 32'd1);
            if (i > 0) begin
                check("stream_valid", 32'(bus.out_valid), 32'd1);
                check("stream_data", 32'(bus.out_data), 32'(rotr(16'h8001, i - 1)));
            end
        end

        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h1111 * 16'(i + 1), 4'(i), 1'b0);
            step();
        end
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        check("prerst_count", 32'(bus.count), 32'd3);
        check("prerst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_data", 32'(bus.out_data), 32'd0);
        check("mrst_count", 32'(bus.count), 32'd0);
        check("mrst_ready", 32'(bus.in_ready), 32'd1);
        check("mrst_aa", 32'(bus.rot_aa), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mrst_no_stale", 32'(bus.out_valid), 32'd0);
        end

        for (int i = 0; i < 300; i++) begin
            if (i < 260) drive(($urandom_range(3) != 0), 16'($urandom), 4'($urandom_range(15)), 1'($urandom_range(1)));
            else drive(1'b0, 16'h0, 4'h0, 1'b0);
            bus.out_ready = (i >= 260) ? 1'b1 : 1'($urandom_range(1));
            do_push = bus.in_valid && bus.in_ready;
            do_take = bus.out_valid && bus.out_ready;
            hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            if (do_push && bus.count == 3 && do_take) full_swap++;
            step();
            if (do_take) begin
                head_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                check("rand_order", 32'(prev_data), 32'(head_exp));
            end
            if (do_push) exp_q.push_back(bus.in_dir ? rotl(bus.in_data, int'(bus.in_amt)) : rotr(bus.in_data, int'(bus.in_amt)));
            if (hold) begin
                check("rand_hold_valid", 32'(bus.out_valid), 32'd1);
                check("rand_hold_data", 32'(bus.out_data), 32'(prev_data));
            end
        end
        check("rand_all_delivered", 32'(exp_q.size()), 32'd0);
        check("rand_final_valid", 32'(bus.out_valid), 32'd0);
        check("rand_swap_at_3_seen", 32'(full_swap > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rotate_request_sequencer.md
Name: rotate_request_sequencer

Overview:
- Upstream/downstream wrapper for the 16-bit combinational rotator (SHO[i] = AA[(i+S) mod 16], i.e. rotate-right by S).
- Accepts rotate requests (data, amount, direction) over a valid/ready handshake and buffers them in a small FIFO.
- Converts direction to the rotator's right-rotate amount, drives the rotator from the FIFO head, and registers the result into a valid/ready output stage.
- Sits between the datapath request source and the result consumer; throughput is one rotate per cycle.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, minimum 2.
- DATA_W, 16, data width; fixed to match the rotator.
- AMT_W, 4, rotate-amount width; equals log2(DATA_W).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  FIFO can accept a request.
- in_data  in  16  operand.
- in_amt  in  4  rotate amount, 0..15.
- in_dir  in  1  0 = rotate right, 1 = rotate left.
- rot_aa  out  16  operand to rotator (AA).
- rot_s  out  4  right-rotate amount to rotator (S).
- rot_sho  in  16  rotator result (SHO), combinational from rot_aa and rot_s.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  16  registered rotate result.
- count  out  3  current FIFO occupancy, 0..DEPTH; width is $clog2(DEPTH+1).

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO pointers and count go to 0; out_valid=0; out_data=16'h0000.
  - in_ready=1 from the cycle after reset.
  - Any in-flight request and any held result are discarded.
- Push: on an edge with in_valid && in_ready, the FIFO stores {in_data, s_eff}.
  - s_eff = in_amt when in_dir=0.
  - s_eff = (16 - in_amt) mod 16 when in_dir=1, computed in 4 bits as (~in_amt + 1).
  - A left rotate by 0 gives s_eff = 0.
- in_ready = (count != DEPTH). A push is refused when full, even if a pop occurs in the same cycle; there is no pass-through.
- Rotator drive: while count>0, rot_aa and rot_s equal the head entry, combinationally from FIFO storage. While empty, rot_aa=0 and rot_s=0.
- Capture/pop:
  - Condition: count>0 && (!out_valid || out_ready).
  - On an edge where it holds: out_data <= rot_sho, out_valid <= 1, FIFO pops the head.
- Drain without new data: on an edge with out_valid && out_ready && count==0, out_valid <= 0 and out_data holds its last value.
- Output stability: while out_valid && !out_ready, out_data and out_valid hold, and the FIFO head is not popped.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: a request pushed at edge k to an empty FIFO with an idle output is captured at edge k+1. out_valid is therefore high in the cycle after edge k+1.
- Throughput: one result per cycle with out_ready held at 1.
- Arithmetic: count is never out of the range 0..DEPTH. The data path has no width change.

Decomposition:
- Package rotate_pkg:
  - Constants DATA_W=16, AMT_W=4.
  - typedef rot_req_t {logic [15:0] data; logic [3:0] s;}.
  - Function to_right_amt(amt, dir).
- Sub-module rotate_req_fifo (DEPTH, storing rot_req_t):
  - Inputs push and pop.
  - Outputs head, count, full, empty.
- Top level: direction conversion, rotator port drive, output register, handshake logic.
- The bench instantiates the rotator between rot_aa/rot_s and rot_sho.

Test Plan:
- Reset, then in_data=16'h0001, in_amt=1, in_dir=0, out_ready=1 -> rot_s=1; out_data=16'h8000 with out_valid one cycle after the accepting edge.
- in_data=16'h0001, in_amt=1, in_dir=1 -> rot_s=15, out_data=16'h0002. in_data=16'hABCD, in_amt=0, in_dir=1 -> rot_s=0, out_data=16'hABCD.
- out_ready=0 while pushing 16'h1234 with amt 4, right, and 5 further requests:
  - out_valid holds 16'h4123.
  - count reaches 4, then in_ready=0 and the 6th request stalls.
  - After out_ready=1, results emerge in order, one per cycle.
- Back-to-back stream of 16 requests (16'h8001, amt 0..15, right) with out_ready=1 -> 16 consecutive valid results matching a reference rotate, with count never above 1.
- Assert rst while count=3 and out_valid=1 -> next cycle out_valid=0, out_data=0, count=0, in_ready=1, rot_aa=0; no stale result appears afterwards.
- Random out_ready toggling with simultaneous push/pop at count=DEPTH-1 -> no loss, duplication or reordering; out_data stable whenever out_valid && !out_ready.
